// File: rtl/led_drv_pkg.sv
// rtl/led_drv_pkg.sv - shared types, constants and helpers for the LED alarm driver
// Purpose : state encoding, default LED count and one-hot LED helper.
// Contents: state_e, LED_W_DEF, ONEHOT_MAX_W, onehot().
package led_drv_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FLASH = 2'd1,
      ST_SWEEP = 2'd2
   } state_e;

   localparam int unsigned LED_W_DEF    = 10;
   // Widest LED bank the helper can address; callers truncate to their width.
   localparam int unsigned ONEHOT_MAX_W = 32;

   function automatic logic [ONEHOT_MAX_W-1:0] onehot(input logic [4:0] pos);
      return ONEHOT_MAX_W'(1) << pos;
   endfunction

endpackage

// File: rtl/led_alarm_driver_tick_prescaler.sv
// rtl/led_alarm_driver_tick_prescaler.sv - free-running divide-by-N tick generator
// Purpose : pulses tick on the last cycle of every N-cycle period.
// Ports   : clk   - system clock
//           reset - synchronous active-high reset
//           clr   - holds/restarts the count at zero, tick suppressed
//           tick  - one-cycle pulse every N cycles while clr is low
module tick_prescaler #(
   parameter int unsigned N = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   output logic tick
);

   localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

   logic [CW-1:0] cnt_q;
   logic          last;

   assign last = (cnt_q == CW'(N - 1));
   assign tick = ~clr & last;

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         cnt_q <= '0;
      end else if (last) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + CW'(1);
      end
   end

endmodule

// File: rtl/led_alarm_driver.sv
// rtl/led_alarm_driver.sv - LED PIO output stage with change flash and alarm sweep
// Purpose : mirrors the LED PIO word onto the LEDs, flashes freshly changed bits,
//           and overrides with a bouncing single-LED sweep while an alarm is raised.
// Ports   : clk, reset            - clock, synchronous active-high reset
//           led_word[LED_W]       - LED PIO out_port value
//           alarm_active          - alarm comparator level
//           alarm_ack             - one-cycle acknowledge pulse
//           led[LED_W]            - registered LED drive, 1 = lit
//           alarm_busy            - registered, high while sweeping
//           alarm_timeout         - one-cycle pulse when a sweep times out
module led_alarm_driver
   import led_drv_pkg::*;
#(
   parameter int unsigned LED_W         = LED_W_DEF,
   parameter int unsigned STEP_CYCLES   = 5000000,
   parameter int unsigned FLASH_CYCLES  = 2500000,
   parameter int unsigned TIMEOUT_STEPS = 600
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [LED_W-1:0] led_word,
   input  logic             alarm_active,
   input  logic             alarm_ack,
   output logic [LED_W-1:0] led,
   output logic             alarm_busy,
   output logic             alarm_timeout
);

   localparam int unsigned POS_W = $clog2(LED_W);
   localparam int unsigned FC_W  = $clog2(FLASH_CYCLES);
   localparam int unsigned TS_W  = $clog2(TIMEOUT_STEPS + 1);

   state_e             state_q, state_d;
   logic [LED_W-1:0]   led_q, led_d;
   logic               busy_q;
   logic               timeout_q, timeout_d;
   logic [LED_W-1:0]   prev_word_q;
   logic               alarm_q;
   logic [LED_W-1:0]   diff_mask_q, diff_mask_d;
   logic [FC_W-1:0]    flash_cnt_q, flash_cnt_d;
   logic [POS_W-1:0]   pos_q, pos_d;
   logic               dir_up_q, dir_up_d;
   logic [TS_W-1:0]    step_total_q, step_total_d;

   logic               rise;
   logic [LED_W-1:0]   diff;
   logic               step_tick;
   logic               timed_out;

   // Step divider only runs while sweeping; entering SWEEP restarts it at zero.
   tick_prescaler #(.N(STEP_CYCLES)) u_step (
      .clk   (clk),
      .reset (reset),
      .clr   (state_q != ST_SWEEP),
      .tick  (step_tick)
   );

   assign rise      = alarm_active & ~alarm_q;
   assign diff      = led_word ^ prev_word_q;
   assign timed_out = (step_total_q == TS_W'(TIMEOUT_STEPS));

   always_comb begin
      state_d      = state_q;
      led_d        = led_q;
      diff_mask_d  = diff_mask_q;
      flash_cnt_d  = flash_cnt_q;
      pos_d        = pos_q;
      dir_up_d     = dir_up_q;
      step_total_d = step_total_q;
      timeout_d    = 1'b0;

      if (rise && (state_q != ST_SWEEP)) begin
         // Alarm entry beats any pending or simultaneous flash.
         state_d      = ST_SWEEP;
         pos_d        = '0;
         dir_up_d     = 1'b1;
         step_total_d = '0;
         diff_mask_d  = '0;
         flash_cnt_d  = '0;
         led_d        = LED_W'(onehot(5'd0));
      end else begin
         case (state_q)
            ST_IDLE: begin
               led_d = led_word;
               if (diff != '0) begin
                  state_d     = ST_FLASH;
                  diff_mask_d = diff;
                  flash_cnt_d = '0;
               end
            end

            ST_FLASH: begin
               if (flash_cnt_q < FC_W'(FLASH_CYCLES / 2)) begin
                  led_d = led_word | diff_mask_q;
               end else begin
                  led_d = led_word & ~diff_mask_q;
               end
               if (diff != '0) begin
                  diff_mask_d = diff_mask_q | diff;
                  flash_cnt_d = '0;
               end else if (flash_cnt_q == FC_W'(FLASH_CYCLES - 1)) begin
                  state_d     = ST_IDLE;
                  diff_mask_d = '0;
                  flash_cnt_d = '0;
               end else begin
                  flash_cnt_d = flash_cnt_q + FC_W'(1);
               end
            end

            ST_SWEEP: begin
               if (alarm_ack || !alarm_active || timed_out) begin
                  state_d   = ST_IDLE;
                  led_d     = led_word;
                  timeout_d = !alarm_ack && alarm_active;
               end else if (step_tick) begin
                  step_total_d = step_total_q + TS_W'(1);
                  if (dir_up_q) begin
                     pos_d    = pos_q + POS_W'(1);
                     dir_up_d = (pos_d != POS_W'(LED_W - 1));
                  end else begin
                     pos_d    = pos_q - POS_W'(1);
                     dir_up_d = (pos_d == '0);
                  end
                  led_d = LED_W'(onehot(5'(pos_d)));
               end
            end

            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         led_q        <= '0;
         busy_q       <= 1'b0;
         timeout_q    <= 1'b0;
         prev_word_q  <= '0;
         alarm_q      <= 1'b0;
         diff_mask_q  <= '0;
         flash_cnt_q  <= '0;
         pos_q        <= '0;
         dir_up_q     <= 1'b1;
         step_total_q <= '0;
      end else begin
         state_q      <= state_d;
         led_q        <= led_d;
         busy_q       <= (state_d == ST_SWEEP);
         timeout_q    <= timeout_d;
         prev_word_q  <= led_word;
         alarm_q      <= alarm_active;
         diff_mask_q  <= diff_mask_d;
         flash_cnt_q  <= flash_cnt_d;
         pos_q        <= pos_d;
         dir_up_q     <= dir_up_d;
         step_total_q <= step_total_d;
      end
   end

   assign led           = led_q;
   assign alarm_busy    = busy_q;
   assign alarm_timeout = timeout_q;

endmodule

// File: tb/tb_led_alarm_driver.sv
// tb/tb_led_alarm_driver.sv - self-checking bench for led_alarm_driver
module tb_led_alarm_driver;

   localparam int W       = 10;
   localparam int STEP    = 4;
   localparam int FLASH   = 8;
   localparam int TIMEOUT = 20;

   logic         clk = 1'b0;
   logic         reset;
   logic [W-1:0] led_word;
   logic         alarm_active;
   logic         alarm_ack;
   logic [W-1:0] led;
   logic         alarm_busy;
   logic         alarm_timeout;

   int n_cmp = 0;
   int n_bad = 0;
   int to_seen = 0;

   // Reference model state
   int           m_mode;      // 0 idle, 1 flash, 2 sweep
   logic [W-1:0] m_prev_word;
   logic         m_prev_alarm;
   logic [W-1:0] m_mask;
   int           m_age;       // cycles since flash (re)start
   int           m_steps;     // sweep steps taken
   int           m_phase;     // cycles into current step
   logic [W-1:0] m_led;
   logic         m_busy;
   logic         m_to;

   led_alarm_driver #(
      .LED_W         (W),
      .STEP_CYCLES   (STEP),
      .FLASH_CYCLES  (FLASH),
      .TIMEOUT_STEPS (TIMEOUT)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .led_word      (led_word),
      .alarm_active  (alarm_active),
      .alarm_ack     (alarm_ack),
      .led           (led),
      .alarm_busy    (alarm_busy),
      .alarm_timeout (alarm_timeout)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // The sweep is a triangle wave over LED positions with period 2*(W-1) steps.
   function automatic logic [W-1:0] sweep_led(input int s);
      int p;
      p = s % (2 * (W - 1));
      if (p > W - 1) p = 2 * (W - 1) - p;
      return W'(1) << p;
   endfunction

   task automatic model_step();
      logic         rise;
      logic [W-1:0] diff;
      if (reset) begin
         m_mode = 0; m_prev_word = '0; m_prev_alarm = 1'b0; m_mask = '0;
         m_age = 0; m_steps = 0; m_phase = 0; m_led = '0; m_busy = 1'b0; m_to = 1'b0;
         return;
      end
      rise = alarm_active && !m_prev_alarm;
      diff = led_word ^ m_prev_word;
      m_to = 1'b0;
      if (rise && m_mode != 2) begin
         m_mode = 2; m_steps = 0; m_phase = 0; m_mask = '0; m_age = 0;
         m_led = sweep_led(0);
      end else if (m_mode == 0) begin
         m_led = led_word;
         if (diff != 0) begin
            m_mode = 1; m_mask = diff; m_age = 0;
         end
      end else if (m_mode == 1) begin
         m_led = (m_age < FLASH / 2) ? (led_word | m_mask) : (led_word & ~m_mask);
         if (diff != 0) begin
            m_mask = m_mask | diff; m_age = 0;
         end else if (m_age == FLASH - 1) begin
            m_mode = 0; m_mask = '0; m_age = 0;
         end else begin
            m_age++;
         end
      end else begin
         if (alarm_ack || !alarm_active || m_steps == TIMEOUT) begin
            m_to   = alarm_active && !alarm_ack;
            m_mode = 0;
            m_led  = led_word;
         end else begin
            m_phase++;
            if (m_phase == STEP) begin
               m_phase = 0;
               m_steps++;
               m_led = sweep_led(m_steps);
            end
         end
      end
      m_prev_word  = led_word;
      m_prev_alarm = alarm_active;
      m_busy       = (m_mode == 2);
   endtask

   task automatic cycle(input logic rst, input logic [W-1:0] w, input logic act, input logic ack);
      @(negedge clk);
      reset = rst; led_word = w; alarm_active = act; alarm_ack = ack;
      model_step();
      @(posedge clk);
      #1;
      check("led", 32'(led), 32'(m_led));
      check("alarm_busy", 32'(alarm_busy), 32'(m_busy));
      check("alarm_timeout", 32'(alarm_timeout), 32'(m_to));
      if (alarm_timeout === 1'b1) to_seen++;
   endtask

   task automatic idle_cycles(input int n, input logic [W-1:0] w, input logic act);
      for (int i = 0; i < n; i++) cycle(1'b0, w, act, 1'b0);
   endtask

   initial begin
      logic [W-1:0] w;
      logic         act;
      logic         ack;
      logic         rst;

      reset = 1'b1; led_word = 10'h3FF; alarm_active = 1'b0; alarm_ack = 1'b0;

      // 1: reset with all-ones word, then the power-on flash
      for (int i = 0; i < 3; i++) cycle(1'b1, 10'h3FF, 1'b0, 1'b0);
      check("reset_led", 32'(led), 32'h0);
      idle_cycles(15, 10'h3FF, 1'b0);
      check("steady_3ff", 32'(led), 32'h3FF);

      // 2: single-bit change, then a second change mid-flash
      idle_cycles(12, 10'h001, 1'b0);
      idle_cycles(20, 10'h003, 1'b0);
      check("steady_003", 32'(led), 32'h003);
      idle_cycles(6, 10'h001, 1'b0);
      idle_cycles(15, 10'h007, 1'b0);
      check("steady_007", 32'(led), 32'h007);

      // 3: alarm rise and sweep
      cycle(1'b0, 10'h007, 1'b1, 1'b0);
      check("sweep_entry_led", 32'(led), 32'h001);
      check("sweep_entry_busy", 32'(alarm_busy), 32'h1);
      idle_cycles(50, 10'h007, 1'b1);

      // 4: acknowledge with alarm still high; no re-entry until a new rise
      cycle(1'b0, 10'h007, 1'b1, 1'b1);
      check("ack_busy", 32'(alarm_busy), 32'h0);
      check("ack_led", 32'(led), 32'h007);
      idle_cycles(10, 10'h007, 1'b1);
      check("no_reentry", 32'(alarm_busy), 32'h0);
      idle_cycles(3, 10'h007, 1'b0);

      // 5: hold alarm long enough to time out
      to_seen = 0;
      idle_cycles(100, 10'h007, 1'b1);
      check("timeout_pulses", 32'(to_seen), 32'd1);
      check("timeout_idle", 32'(alarm_busy), 32'h0);
      idle_cycles(3, 10'h007, 1'b0);

      // 6: rise coincident with word change, then reset mid-sweep
      idle_cycles(14, 10'h00F, 1'b1);
      check("no_flash_after", 32'(led), 32'h008);
      cycle(1'b1, 10'h00F, 1'b1, 1'b0);
      check("reset_mid_led", 32'(led), 32'h0);
      check("reset_mid_busy", 32'(alarm_busy), 32'h0);
      cycle(1'b1, 10'h00F, 1'b1, 1'b0);
      idle_cycles(10, 10'h00F, 1'b1);
      idle_cycles(10, 10'h00F, 1'b0);

      // Randomized phase
      w = 10'h00F; act = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 5) == 0) begin
            if ($urandom_range(0, 1) == 0) w = W'($urandom);
            else w = w ^ (W'(1) << $urandom_range(0, W - 1));
         end
         if ($urandom_range(0, 49) == 0) act = ~act;
         ack = ($urandom_range(0, 59) == 0);
         rst = ($urandom_range(0, 499) == 0);
         cycle(rst, w, act, ack);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/led_alarm_driver.md
Name: led_alarm_driver

Overview:
Downstream stage of the 10-bit LED PIO output port. It consumes the PIO's `out_port` word and drives the physical LEDR[9:0] pins.
- Normally mirrors the word, briefly flashing any bits that just changed.
- While the alarm comparator asserts the alarm, overrides the LEDs with a bouncing single-LED sweep until acknowledged, deasserted or timed out.

Parameters:
- LED_W, 10, LED count; width of `led_word` and `led`.
- STEP_CYCLES, 5000000, clk cycles per sweep step (100 ms at 50 MHz).
- FLASH_CYCLES, 2500000, total length of a change flash; must be even.
- TIMEOUT_STEPS, 600, sweep steps before automatic alarm stop (60 s).

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- led_word  in  LED_W  LED PIO `out_port` value.
- alarm_active  in  1  level from the alarm comparator.
- alarm_ack  in  1  one-cycle pulse from the debounced KEY.
- led  out  LED_W  registered LED drive; 1 = lit.
- alarm_busy  out  1  registered; 1 while in SWEEP.
- alarm_timeout  out  1  one-cycle pulse when a sweep ends by timeout.

Behaviour:
- Reset (synchronous, sampled on clk rise): state=IDLE, led=0, alarm_busy=0, alarm_timeout=0, prev_word=0, alarm_q=0, diff_mask=0, all counters=0.
- All outputs are registered. `led` reflects inputs one cycle after sampling.
- alarm_q <= alarm_active every cycle. rise = alarm_active & ~alarm_q.
- prev_word <= led_word every cycle in all states. diff = led_word ^ prev_word.
- States: IDLE, FLASH, SWEEP. Transitions are evaluated in this priority order.
- Any state, rise=1 and state!=SWEEP -> SWEEP:
  - pos=0, dir=up, step_div=0, step_total=0, led=onehot(0).
  - SWEEP wins over a simultaneous led_word change; no flash follows.
- IDLE:
  - led <= led_word.
  - diff!=0 -> FLASH, with diff_mask=diff and flash_cnt=0.
  - alarm_ack is ignored.
- FLASH:
  - flash_cnt < FLASH_CYCLES/2: led <= led_word | diff_mask.
  - Otherwise: led <= led_word & ~diff_mask.
  - A new diff!=0: diff_mask |= diff and flash_cnt restarts at 0.
  - flash_cnt == FLASH_CYCLES-1 with no new diff -> IDLE, diff_mask=0; next led = led_word.
  - alarm_ack is ignored.
- SWEEP:
  - led = onehot(pos).
  - Exit checks, in priority order; each goes to IDLE with led <= led_word on the next cycle and no flash:
    1. alarm_ack=1.
    2. alarm_active=0.
    3. step_total reaches TIMEOUT_STEPS; also pulse alarm_timeout for one cycle.
  - Otherwise step_div counts 0..STEP_CYCLES-1. At wrap, take one step:
    - pos moves one place in dir; step_total++.
    - At pos=LED_W-1, dir becomes down; at pos=0, dir becomes up.
    - Sequence is 0,1,...,9,8,...,1,0,1...; end LEDs are never repeated.
- Re-entry to SWEEP needs a new rising edge. alarm_active held high after ack or timeout stays in IDLE.
- Counter widths: $clog2 of their max value. No counter wraps outside its stated range.
- alarm_busy = (next state == SWEEP), registered.

Decomposition:
- Package led_drv_pkg:
  - state enum {IDLE, FLASH, SWEEP}.
  - LED_W default constant.
  - onehot(pos) function.
- One sub-module, tick_prescaler:
  - Parameter N; ports clk, reset, clr, tick.
  - tick pulses every N cycles; clr restarts the count.
  - Produces the sweep step tick. The FLASH counter stays inline.

Test Plan:
Sim parameters: STEP_CYCLES=4, FLASH_CYCLES=8, TIMEOUT_STEPS=20.
1. Reset with led_word=10'h3FF: led=0 during reset. First cycle after release: FLASH (diff=3FF); led=3FF for 4 cycles, 000 for 4 cycles, then 3FF steady.
2. From steady led_word=10'h001, write 10'h003: led=003 for 4 cycles, 001 for 4 cycles, then 003. Second write 10'h007 at flash cycle 5: diff_mask=006 and the count restarts.
3. alarm_active rises: alarm_busy=1 next cycle and led=001. led steps every 4 cycles: 002, 004 ... 200, 100 ... 001, 002.
4. alarm_ack pulse mid-sweep with alarm_active still high: next cycle IDLE, led=led_word, alarm_busy=0. No re-entry until alarm_active falls and rises again.
5. Hold alarm_active for 100 cycles: after 20 steps, alarm_timeout pulses exactly once, state goes to IDLE, and alarm_busy=0.
6. Alarm rise coincident with a led_word change; then reset asserted mid-sweep: SWEEP entered with no FLASH afterwards. On reset, led=0 and alarm_busy=0 on the next edge.
